// File: rtl/a_bus_scheduler.sv
// Registered bus arbiter: grant lands one cycle after a request is seen in IDLE, handovers wait on ctrl_ack.
// Fixed priority with preemption or round robin, plus a hold-count split once a master has had the bus THRESH cycles.
module a_bus_scheduler #(
   parameter int NO_MASTERS = 4,
   parameter int NO_SLAVES  = 3,
   parameter int S_ID_WIDTH = $clog2(NO_SLAVES + 1),
   parameter int M_ID_WIDTH = (NO_MASTERS > 1) ? $clog2(NO_MASTERS) : 1,
   parameter int THRESH     = 8,
   parameter int CNT_WIDTH  = $clog2(THRESH + 1)
) (
   input  logic                  clk,
   input  logic                  rstN,
   input  logic                  mode,
   input  logic [S_ID_WIDTH-1:0] slave_id [0:NO_MASTERS-1],
   input  logic                  done,
   input  logic                  ctrl_ack,
   output logic                  grant_valid,
   output logic [M_ID_WIDTH-1:0] master_out,
   output logic [S_ID_WIDTH-1:0] slave_out,
   output logic                  new_grant,
   output logic                  switch_req,
   output logic                  switch_split,
   output logic                  grant_resume
);

   typedef enum logic [1:0] {IDLE, BUSY, HANDOVER} state_t;

   typedef struct packed {
      logic                  hit;
      logic [M_ID_WIDTH-1:0] idx;
   } pick_t;

   localparam logic [M_ID_WIDTH-1:0] LAST_M = M_ID_WIDTH'(NO_MASTERS - 1);

   // Fixed priority is a round-robin scan that starts just after the last index.
   function automatic pick_t pick(input logic [NO_MASTERS-1:0] mask,
                                  input logic                  rr,
                                  input logic [M_ID_WIDTH-1:0] ptr);
      pick_t                 r;
      logic [M_ID_WIDTH-1:0] idx;
      r   = '0;
      idx = rr ? ptr : LAST_M;
      for (int k = 0; k < NO_MASTERS; k++) begin
         idx = (idx == LAST_M) ? '0 : idx + M_ID_WIDTH'(1);
         if (mask[idx] && !r.hit) begin
            r.hit = 1'b1;
            r.idx = idx;
         end
      end
      return r;
   endfunction

   state_t                  state_q, state_d;
   logic                    grant_valid_q, grant_valid_d;
   logic [M_ID_WIDTH-1:0]   master_q, master_d;
   logic [S_ID_WIDTH-1:0]   slave_q, slave_d;
   logic                    new_grant_q, new_grant_d;
   logic                    switch_req_q, switch_req_d;
   logic                    switch_split_q, switch_split_d;
   logic                    grant_resume_q, grant_resume_d;
   logic [CNT_WIDTH-1:0]    hold_cnt_q, hold_cnt_d;
   logic [M_ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
   logic [NO_MASTERS-1:0]   susp_q, susp_d;
   logic [M_ID_WIDTH-1:0]   cand_q, cand_d;

   logic [NO_MASTERS-1:0]   req, split_mask, pre_mask;
   pick_t                   sel, split_pick, pre_pick;
   logic                    do_grant;
   logic [M_ID_WIDTH-1:0]   gnt_idx;

   always_comb begin
      for (int i = 0; i < NO_MASTERS; i++) begin
         req[i]        = (slave_id[i] != '0);
         split_mask[i] = req[i] && (M_ID_WIDTH'(i) != master_q) && (slave_id[i] != slave_q);
         pre_mask[i]   = req[i] && (M_ID_WIDTH'(i) < master_q);
      end
      sel        = pick(req, mode, rr_ptr_q);
      split_pick = pick(split_mask, mode, rr_ptr_q);
      pre_pick   = pick(pre_mask, 1'b0, '0);
   end

   always_comb begin
      state_d        = state_q;
      grant_valid_d  = grant_valid_q;
      master_d       = master_q;
      slave_d        = slave_q;
      new_grant_d    = 1'b0;
      switch_req_d   = switch_req_q;
      switch_split_d = switch_split_q;
      grant_resume_d = 1'b0;
      hold_cnt_d     = hold_cnt_q;
      rr_ptr_d       = rr_ptr_q;
      susp_d         = susp_q;
      cand_d         = cand_q;
      do_grant       = 1'b0;
      gnt_idx        = '0;

      case (state_q)
         IDLE: begin
            if (sel.hit) begin
               do_grant = 1'b1;
               gnt_idx  = sel.idx;
            end
         end
         BUSY: begin
            if (hold_cnt_q != CNT_WIDTH'(THRESH)) hold_cnt_d = hold_cnt_q + CNT_WIDTH'(1);
            if (done) begin
               grant_valid_d = 1'b0;
               state_d       = IDLE;
            end else if (hold_cnt_q == CNT_WIDTH'(THRESH) && split_pick.hit) begin
               switch_req_d   = 1'b1;
               switch_split_d = 1'b1;
               cand_d         = split_pick.idx;
               state_d        = HANDOVER;
            end else if (!mode && pre_pick.hit) begin
               switch_req_d   = 1'b1;
               switch_split_d = 1'b0;
               cand_d         = pre_pick.idx;
               state_d        = HANDOVER;
            end
         end
         HANDOVER: begin
            if (done) begin
               grant_valid_d  = 1'b0;
               switch_req_d   = 1'b0;
               switch_split_d = 1'b0;
               state_d        = IDLE;
            end else if (ctrl_ack) begin
               susp_d[master_q] = 1'b1;
               switch_req_d     = 1'b0;
               switch_split_d   = 1'b0;
               if (req[cand_q]) begin
                  do_grant = 1'b1;
                  gnt_idx  = cand_q;
               end else begin
                  grant_valid_d = 1'b0;
                  state_d       = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (do_grant) begin
         grant_valid_d   = 1'b1;
         new_grant_d     = 1'b1;
         master_d        = gnt_idx;
         slave_d         = slave_id[gnt_idx];
         grant_resume_d  = susp_d[gnt_idx];
         susp_d[gnt_idx] = 1'b0;
         rr_ptr_d        = gnt_idx;
         hold_cnt_d      = '0;
         state_d         = BUSY;
      end
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q        <= IDLE;
         grant_valid_q  <= 1'b0;
         master_q       <= '0;
         slave_q        <= '0;
         new_grant_q    <= 1'b0;
         switch_req_q   <= 1'b0;
         switch_split_q <= 1'b0;
         grant_resume_q <= 1'b0;
         hold_cnt_q     <= '0;
         rr_ptr_q       <= LAST_M;
         susp_q         <= '0;
         cand_q         <= '0;
      end else begin
         state_q        <= state_d;
         grant_valid_q  <= grant_valid_d;
         master_q       <= master_d;
         slave_q        <= slave_d;
         new_grant_q    <= new_grant_d;
         switch_req_q   <= switch_req_d;
         switch_split_q <= switch_split_d;
         grant_resume_q <= grant_resume_d;
         hold_cnt_q     <= hold_cnt_d;
         rr_ptr_q       <= rr_ptr_d;
         susp_q         <= susp_d;
         cand_q         <= cand_d;
      end
   end

   assign grant_valid  = grant_valid_q;
   assign master_out   = master_q;
   assign slave_out    = slave_q;
   assign new_grant    = new_grant_q;
   assign switch_req   = switch_req_q;
   assign switch_split = switch_split_q;
   assign grant_resume = grant_resume_q;

endmodule

// File: tb/tb_a_bus_scheduler.sv
// Directed bench for a_bus_scheduler (4 masters, 3 slaves, THRESH=8) with hand-computed expectations.
module tb_a_bus_scheduler;

   logic       clk = 1'b0;
   logic       rstN;
   logic       mode;
   logic [1:0] sid [0:3];
   logic       done;
   logic       ctrl_ack;
   logic       grant_valid;
   logic [1:0] master_out;
   logic [1:0] slave_out;
   logic       new_grant;
   logic       switch_req;
   logic       switch_split;
   logic       grant_resume;

   int checks   = 0;
   int failures = 0;

   a_bus_scheduler dut (
      .clk          (clk),
      .rstN         (rstN),
      .mode         (mode),
      .slave_id     (sid),
      .done         (done),
      .ctrl_ack     (ctrl_ack),
      .grant_valid  (grant_valid),
      .master_out   (master_out),
      .slave_out    (slave_out),
      .new_grant    (new_grant),
      .switch_req   (switch_req),
      .switch_split (switch_split),
      .grant_resume (grant_resume)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, ".grant_valid"},  32'(grant_valid),  0);
      check({tag, ".master_out"},   32'(master_out),   0);
      check({tag, ".slave_out"},    32'(slave_out),    0);
      check({tag, ".new_grant"},    32'(new_grant),    0);
      check({tag, ".switch_req"},   32'(switch_req),   0);
      check({tag, ".switch_split"}, 32'(switch_split), 0);
      check({tag, ".grant_resume"}, 32'(grant_resume), 0);
   endtask

   initial begin
      int rr_exp_m [5];
      int rr_exp_r [5];
      rr_exp_m = '{0, 1, 2, 3, 0};
      rr_exp_r = '{1, 0, 0, 0, 0};

      rstN = 1'b0; mode = 1'b0; done = 1'b0; ctrl_ack = 1'b0;
      for (int i = 0; i < 4; i++) sid[i] = 2'd0;
      step(); step();
      check_idle_outputs("reset");
      rstN = 1'b1;

      // Basic grant, then one IDLE turnaround before master 3.
      sid[0] = 2'd0; sid[1] = 2'd2; sid[2] = 2'd0; sid[3] = 2'd1;
      step();
      check("basic.gv",  32'(grant_valid), 1);
      check("basic.m",   32'(master_out),  1);
      check("basic.s",   32'(slave_out),   2);
      check("basic.ng",  32'(new_grant),   1);
      step();
      check("basic.ng_pulse", 32'(new_grant), 0);
      done = 1'b1; sid[1] = 2'd0;
      step();
      done = 1'b0;
      check("basic.turnaround_gv", 32'(grant_valid), 0);
      step();
      check("basic.m3",  32'(master_out), 3);
      check("basic.s3",  32'(slave_out),  1);
      check("basic.ng3", 32'(new_grant),  1);
      done = 1'b1; sid[3] = 2'd0;
      step();
      done = 1'b0;
      step();

      // Preemption of master 2 by master 0, then resume of master 2.
      sid[2] = 2'd1;
      step();
      check("pre.m2", 32'(master_out), 2);
      step(); step();
      sid[0] = 2'd1;
      step();
      check("pre.req",   32'(switch_req),   1);
      check("pre.split", 32'(switch_split), 0);
      check("pre.m_hold", 32'(master_out),  2);
      step();
      check("pre.req_held", 32'(switch_req), 1);
      ctrl_ack = 1'b1;
      step();
      ctrl_ack = 1'b0;
      check("pre.m0",     32'(master_out),   0);
      check("pre.ng0",    32'(new_grant),    1);
      check("pre.req_off", 32'(switch_req),  0);
      check("pre.res0",   32'(grant_resume), 0);
      done = 1'b1; sid[0] = 2'd0;
      step();
      done = 1'b0;
      check("pre.idle_gv", 32'(grant_valid), 0);
      step();
      check("pre.m2_back", 32'(master_out),   2);
      check("pre.resume",  32'(grant_resume), 1);
      step();
      check("pre.resume_pulse", 32'(grant_resume), 0);
      done = 1'b1; sid[2] = 2'd0;
      step();
      done = 1'b0;
      step();

      // Split in round-robin mode after THRESH hold cycles.
      mode = 1'b1;
      sid[0] = 2'd1;
      step();
      check("split.m0", 32'(master_out), 0);
      sid[3] = 2'd2;
      for (int k = 0; k < 8; k++) begin
         step();
         check("split.no_switch", 32'(switch_req), 0);
      end
      step();
      check("split.req",   32'(switch_req),   1);
      check("split.split", 32'(switch_split), 1);
      ctrl_ack = 1'b1;
      step();
      ctrl_ack = 1'b0;
      check("split.m3", 32'(master_out), 3);
      check("split.s2", 32'(slave_out),  2);
      check("split.ng", 32'(new_grant),  1);
      done = 1'b1; sid[0] = 2'd0; sid[3] = 2'd0;
      step();
      done = 1'b0;
      step();

      // Round robin: park pointer on master 3, then all request slave 1.
      sid[3] = 2'd1;
      step();
      check("rr.prime", 32'(master_out), 3);
      done = 1'b1; sid[3] = 2'd0;
      step();
      done = 1'b0;
      for (int i = 0; i < 4; i++) sid[i] = 2'd1;
      step();
      for (int g = 0; g < 5; g++) begin
         if (g > 0) begin
            done = 1'b1;
            step();
            done = 1'b0;
            step();
         end
         check($sformatf("rr.order%0d", g),  32'(master_out),   32'(rr_exp_m[g]));
         check($sformatf("rr.resume%0d", g), 32'(grant_resume), 32'(rr_exp_r[g]));
      end
      for (int i = 0; i < 4; i++) sid[i] = 2'd0;
      done = 1'b1;
      step();
      done = 1'b0;
      step();

      // done and ctrl_ack together in HANDOVER: done wins, no suspension.
      mode = 1'b0;
      sid[2] = 2'd1;
      step();
      check("col.m2", 32'(master_out), 2);
      sid[0] = 2'd2;
      step();
      check("col.req", 32'(switch_req), 1);
      done = 1'b1; ctrl_ack = 1'b1; sid[0] = 2'd0;
      step();
      done = 1'b0; ctrl_ack = 1'b0;
      check("col.gv",  32'(grant_valid), 0);
      check("col.req_off", 32'(switch_req), 0);
      check("col.split_off", 32'(switch_split), 0);
      step();
      check("col.m2_again", 32'(master_out),   2);
      check("col.no_resume", 32'(grant_resume), 0);

      // Suspend master 2, split-handover back, reset mid-HANDOVER.
      sid[0] = 2'd2;
      step();
      check("ares.pre_req", 32'(switch_req), 1);
      ctrl_ack = 1'b1;
      step();
      ctrl_ack = 1'b0;
      check("ares.m0", 32'(master_out), 0);
      for (int k = 0; k < 9; k++) step();
      check("ares.split_req", 32'(switch_req),   1);
      check("ares.split_q",   32'(switch_split), 1);
      #2;
      rstN = 1'b0;
      #1;
      check_idle_outputs("ares");
      rstN = 1'b1;
      sid[0] = 2'd0;
      step();
      check("ares.m2",     32'(master_out),   2);
      check("ares.ng",     32'(new_grant),    1);
      check("ares.resume", 32'(grant_resume), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
